// File: rtl/intc_ctrl.sv
// ----------------------------------------------------------------------------
// intc_ctrl - interrupt controller for the single-cycle IO processor.
//
// Latches requests from NIRQ external lines, arbitrates them by fixed
// priority (lowest index wins) and forces the PC to a per-line vector
// VEC_BASE + 2*i. The interrupted PC is saved in epc and restored on RETI.
// The irq_take/ret_take outputs override the uc jump select in the PC mux.
// irq_take also squashes register/port writes in the take cycle.
//
// Build option:
//   INTC_LEVEL_EN  defined   -> level-sensitive requests (pending = irq).
//                  undefined -> edge-latched requests (default).
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   irq       in   [NIRQ]  request lines (synchronous to clk)
//   mask_we   in   enable-mask write strobe
//   mask_d    in   [NIRQ]  new enable mask (1 = enabled)
//   pc_cur    in   [PC_W]  address of the instruction executing this cycle
//   reti      in   decoded RETI strobe
//   halt      in   uc fin; blocks interrupt take
//   irq_take  out  PC mux select: load vec on the next edge
//   vec       out  [PC_W]  vector address (0 unless irq_take)
//   ret_take  out  PC mux select: load ret_addr on the next edge
//   ret_addr  out  [PC_W]  saved PC (epc)
//   in_isr    out  handler active
//   pending   out  [NIRQ]  latched requests
//   mask      out  [NIRQ]  current enable mask
//   err       out  sticky: RETI received outside a handler
// ----------------------------------------------------------------------------
module intc_ctrl #(
    parameter int unsigned    PC_W     = 10,
    parameter int unsigned    NIRQ     = 4,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3F0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_d,
    input  logic [PC_W-1:0] pc_cur,
    input  logic            reti,
    input  logic            halt,
    output logic            irq_take,
    output logic [PC_W-1:0] vec,
    output logic            ret_take,
    output logic [PC_W-1:0] ret_addr,
    output logic            in_isr,
    output logic [NIRQ-1:0] pending,
    output logic [NIRQ-1:0] mask,
    output logic            err
);

    localparam int unsigned ID_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAKE = 2'd1,
        ISR  = 2'd2,
        RET  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] win_id;
    logic            found;
    logic            take_go;
    logic [PC_W-1:0] epc;
    logic [NIRQ-1:0] cand;

`ifndef INTC_LEVEL_EN
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] irq_edge;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] pend_r;

    assign irq_edge = irq & ~irq_q;
    assign pending  = pend_r;
`else
    // Level mode: the request line itself is the pending bit; the handler
    // must deassert the line, so nothing is latched or cleared here.
    assign pending = irq;
`endif

    assign cand     = pending & mask;
    assign ret_addr = epc;

    // Fixed priority: lowest index wins.
    always_comb begin
        found  = 1'b0;
        win_id = '0;
        for (int unsigned i = 0; i < NIRQ; i++) begin
            if (cand[i] && !found) begin
                found  = 1'b1;
                win_id = ID_W'(i);
            end
        end
    end

    always_comb begin
        state_n  = state;
        take_go  = 1'b0;
        irq_take = 1'b0;
        ret_take = 1'b0;
        in_isr   = 1'b0;
        vec      = '0;
`ifndef INTC_LEVEL_EN
        clr      = '0;
`endif
        case (state)
            IDLE: begin
                if (found && !halt) begin
                    state_n = TAKE;
                    take_go = 1'b1;
`ifndef INTC_LEVEL_EN
                    clr[win_id] = 1'b1;
`endif
                end
            end
            TAKE: begin
                irq_take = 1'b1;
                vec      = VEC_BASE + (PC_W'(cur_id) << 1);
                state_n  = ISR;
            end
            ISR: begin
                in_isr = 1'b1;
                if (reti && !halt) begin
                    state_n = RET;
                end
            end
            RET: begin
                ret_take = 1'b1;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cur_id <= '0;
            epc    <= '0;
            err    <= 1'b0;
            mask   <= '0;
`ifndef INTC_LEVEL_EN
            pend_r <= '0;
            // All ones: a line already high at reset release must fall and
            // rise again before it requests.
            irq_q  <= '1;
`endif
        end else begin
            state <= state_n;
            if (take_go) begin
                cur_id <= win_id;
            end
            // The instruction in the take cycle is squashed, so it is the
            // one that re-executes after return.
            if (state == TAKE) begin
                epc <= pc_cur;
            end
            if (reti && (state == IDLE || state == TAKE)) begin
                err <= 1'b1;
            end
            if (mask_we) begin
                mask <= mask_d;
            end
`ifndef INTC_LEVEL_EN
            irq_q  <= irq;
            pend_r <= (pend_r & ~clr) | irq_edge;
`endif
        end
    end

endmodule

// File: tb/tb_intc_ctrl.sv
module tb_intc_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_d;
    logic [9:0] pc_cur;
    logic       reti;
    logic       halt;
    logic       irq_take;
    logic [9:0] vec;
    logic       ret_take;
    logic [9:0] ret_addr;
    logic       in_isr;
    logic [3:0] pending;
    logic [3:0] mask;
    logic       err;

    intc_ctrl #(.PC_W(10), .NIRQ(4), .VEC_BASE(10'h3F0)) dut (
        .clk      (clk),
        .reset    (reset),
        .irq      (irq),
        .mask_we  (mask_we),
        .mask_d   (mask_d),
        .pc_cur   (pc_cur),
        .reti     (reti),
        .halt     (halt),
        .irq_take (irq_take),
        .vec      (vec),
        .ret_take (ret_take),
        .ret_addr (ret_addr),
        .in_isr   (in_isr),
        .pending  (pending),
        .mask     (mask),
        .err      (err)
    );

    typedef struct {
        bit         is_ret;
        logic [9:0] addr;
    } exp_t;

    exp_t exq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_take(input logic [9:0] v);
        exp_t e;
        e.is_ret = 1'b0;
        e.addr   = v;
        exq.push_back(e);
    endtask

    task automatic push_ret(input logic [9:0] a);
        exp_t e;
        e.is_ret = 1'b1;
        e.addr   = a;
        exq.push_back(e);
    endtask

    // Monitor: every take/return the DUT presents must match the next
    // expected event; anything presented with nothing expected is an error.
    always @(negedge clk) begin
        if (!reset && (irq_take || ret_take)) begin
            exp_t e;
            if (irq_take && ret_take) begin
                n_cmp++;
                n_bad++;
                $display("FAIL both_takes: irq_take=1 and ret_take=1 together");
            end else if (exq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_take: irq_take=%0b ret_take=%0b vec=%h ret_addr=%h, expected none",
                         irq_take, ret_take, vec, ret_addr);
            end else begin
                e = exq.pop_front();
                if (e.is_ret) begin
                    check("ret_kind", {31'd0, ret_take}, 32'd1);
                    check("ret_addr", {22'd0, ret_addr}, {22'd0, e.addr});
                end else begin
                    check("take_kind", {31'd0, irq_take}, 32'd1);
                    check("take_vec", {22'd0, vec}, {22'd0, e.addr});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset   = 1'b1;
        irq     = 4'b0001;
        mask_we = 1'b0;
        mask_d  = 4'b0000;
        pc_cur  = 10'h100;
        reti    = 1'b0;
        halt    = 1'b0;
        tick();
        tick();
        check("rst_irq_take", {31'd0, irq_take}, 32'd0);
        check("rst_ret_take", {31'd0, ret_take}, 32'd0);
        check("rst_in_isr",   {31'd0, in_isr},   32'd0);
        check("rst_pending",  {28'd0, pending},  32'd0);
        check("rst_mask",     {28'd0, mask},     32'd0);
        check("rst_err",      {31'd0, err},      32'd0);
        check("rst_ret_addr", {22'd0, ret_addr}, 32'd0);
        check("rst_vec",      {22'd0, vec},      32'd0);

        // Line held high through reset release must not request.
        reset   = 1'b0;
        mask_we = 1'b1;
        mask_d  = 4'b1111;
        tick();
        mask_we = 1'b0;
        check("mask_write", {28'd0, mask}, 32'h0000000F);
        repeat (10) tick();
        check("held_no_pending", {28'd0, pending}, 32'd0);
        irq = 4'b0000;
        tick();
        push_take(10'h3F0);
        irq = 4'b0001;
        tick();
        check("pending_line0", {28'd0, pending}, 32'h1);
        tick();
        tick();
        check("isr_entered", {31'd0, in_isr}, 32'd1);
        check("epc_t1", {22'd0, ret_addr}, 32'h100);
        push_ret(10'h100);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();

        // Simultaneous edges on lines 1 and 3.
        pc_cur = 10'h025;
        irq    = 4'b1010;
        push_take(10'h3F2);
        tick();
        tick();
        check("pending_after_take1", {28'd0, pending}, 32'h8);
        tick();
        check("epc_t2", {22'd0, ret_addr}, 32'h025);
        push_ret(10'h025);
        push_take(10'h3F6);
        reti = 1'b1;
        tick();
        reti   = 1'b0;
        pc_cur = 10'h0AB;
        tick();
        tick();
        tick();
        check("epc_t2b", {22'd0, ret_addr}, 32'h0AB);
        push_ret(10'h0AB);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();

        // Masked request stays pending, taken after the mask write.
        mask_we = 1'b1;
        mask_d  = 4'b0000;
        tick();
        mask_we = 1'b0;
        pc_cur  = 10'h0C0;
        irq     = 4'b0100;
        tick();
        check("masked_pending", {28'd0, pending}, 32'h4);
        repeat (3) tick();
        push_take(10'h3F4);
        mask_we = 1'b1;
        mask_d  = 4'b0100;
        tick();
        mask_we = 1'b0;
        check("mask_line2", {28'd0, mask}, 32'h4);
        tick();
        tick();

        // No nesting: a request during the handler only latches.
        mask_we = 1'b1;
        mask_d  = 4'b1111;
        irq     = 4'b0101;
        tick();
        mask_we = 1'b0;
        check("isr_pending0", {28'd0, pending}, 32'h1);
        halt = 1'b1;
        tick();
        tick();
        check("isr_halt_stay", {31'd0, in_isr}, 32'd1);
        halt = 1'b0;
        push_ret(10'h0C0);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        halt = 1'b1;
        tick();
        repeat (3) tick();
        check("halt_pending", {28'd0, pending}, 32'h1);
        check("halt_idle", {31'd0, in_isr}, 32'd0);
        pc_cur = 10'h155;
        push_take(10'h3F0);
        halt = 1'b0;
        tick();
        tick();
        push_ret(10'h155);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        tick();

        // Stray RETI sets the sticky error.
        reti = 1'b1;
        tick();
        reti = 1'b0;
        check("err_set", {31'd0, err}, 32'd1);
        tick();
        tick();
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset in the middle of a handler.
        irq = 4'b0111;
        push_take(10'h3F2);
        tick();
        tick();
        tick();
        check("isr_before_reset", {31'd0, in_isr}, 32'd1);
        irq = 4'b1111;
        tick();
        check("pending_before_reset", {28'd0, pending}, 32'h8);
        #2;
        reset = 1'b1;
        #1;
        check("async_in_isr",  {31'd0, in_isr},   32'd0);
        check("async_pending", {28'd0, pending},  32'd0);
        check("async_err",     {31'd0, err},      32'd0);
        check("async_epc",     {22'd0, ret_addr}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (4) tick();
        check("queue_empty", exq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intc_ctrl.md
Name: intc_ctrl

Overview:
- Interrupt controller for the single-cycle IO processor.
- Latches requests from 4 external lines (one per IO port), arbitrates them by fixed priority and forces the PC to a per-line vector.
- Saves the interrupted PC and restores it on RETI.
- Sits beside the PC mux: its outputs override the uc jump select and squash register/port writes in the take cycle.

Parameters:
- PC_W, 10, PC/jump-address width (matches instruction bits [15:6]).
- NIRQ, 4, number of request lines.
- VEC_BASE, 10'h3F0, vector base; vector of line i = VEC_BASE + 2*i (PC_W-bit, wraps modulo 2^PC_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq  in  NIRQ  request lines, synchronous to clk; rising edge = request.
- mask_we  in  1  write strobe for the enable mask.
- mask_d  in  NIRQ  new mask value (1 = enabled).
- pc_cur  in  PC_W  address of the instruction executing this cycle.
- reti  in  1  decoded RETI strobe from uc, 1 cycle.
- halt  in  1  uc fin; blocks interrupt take.
- irq_take  out  1  PC mux select: load vec next edge; also squashes we3/we_s_r_x this cycle.
- vec  out  PC_W  vector address, valid while irq_take=1, otherwise 0.
- ret_take  out  1  PC mux select: load ret_addr next edge.
- ret_addr  out  PC_W  saved PC (epc).
- in_isr  out  1  handler active.
- pending  out  NIRQ  latched requests.
- mask  out  NIRQ  current enable mask.
- err  out  1  sticky: RETI received outside a handler.

Behaviour:
- Reset values: state=IDLE; pending=0; mask=0; epc=0; cur_id=0; err=0; irq_q=all ones. All outputs are 0 except ret_addr=epc=0.
  - Because irq_q resets to ones, a line held high through reset release does not request. It must fall, then rise.
- Edge detection: edge[i] = irq[i] & ~irq_q[i]. irq_q <= irq every cycle.
- Pending update: pending[i] <= (pending[i] & ~clr[i]) | edge[i].
  - Set wins over clear in the same cycle.
  - A line stays pending while masked and can be taken later once unmasked.
- Mask: mask <= mask_d on mask_we.
  - A take decision in the same cycle uses the old mask.
- Arbitration: cand = pending & mask. Lowest index wins.
- FSM:
  - IDLE: if |cand and !halt -> TAKE. Capture cur_id = winner; clr[winner] = 1.
  - TAKE (1 cycle): irq_take=1, vec = VEC_BASE + 2*cur_id. epc <= pc_cur, so the squashed instruction re-executes after return. -> ISR.
  - ISR: in_isr=1. No new take (no nesting); requests keep latching. reti -> RET.
  - RET (1 cycle): ret_take=1, ret_addr=epc. -> IDLE.
- Other states:
  - halt in ISR: stay in ISR.
  - reti in IDLE or TAKE: ignored for flow, err <= 1.
  - reti in RET: ignored, no err.
- Latency:
  - Edge sampled at edge n.
  - pending visible after edge n.
  - TAKE entered at edge n+1; PC = vec after edge n+2.
  - Back-to-back: after RET, IDLE may re-take in the next cycle.
- irq_take and ret_take are never high together.
- Reset mid-ISR aborts to IDLE: epc is lost and pending is cleared.

Optional Feature:
- Macro INTC_LEVEL_EN.
- Defined: level-sensitive mode. pending[i] = irq[i] directly; there is no latch and no clear. The line must be deasserted by the handler. A request dropped before TAKE is never taken.
- Undefined: edge-latched behaviour as above.

Test Plan:
- Reset with irq=4'b0001 held; mask=4'b1111 -> no take within 10 cycles; then drop and raise irq[0] -> irq_take=1 two cycles later, vec=10'h3F0.
- irq=4'b1010 edges in the same cycle, mask=4'b1111, pc_cur=10'h025 -> take line 1 (vec=10'h3F2), epc=10'h025, pending=4'b1000.
  - RETI -> ret_take=1, ret_addr=10'h025; next cycle take line 3 (vec=10'h3F6).
- mask=4'b0000, edge on irq[2] -> pending=4'b0100, no take; mask_we with 4'b0100 -> take line 2 in the cycle after the write.
- In ISR, edge on irq[0] -> pending[0]=1 but no irq_take until RET completes; halt=1 in IDLE with pending -> no take.
- reti pulse in IDLE -> err=1, stays 1 until reset; assert reset during ISR -> in_isr=0, pending=0 immediately (asynchronous).
